// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat dealing engine.
package baccarat_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_BLANK = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_TEN   = 4'd10;
  localparam card_t CARD_KING  = 4'd13;

  typedef enum logic [2:0] {
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_THIRD,
    S_BANK,
    S_DONE
  } deal_state_e;

  // Baccarat point value: A..9 count face value, tens/faces and blank count zero.
  function automatic logic [3:0] card_value(input card_t c);
    return (c >= CARD_ACE && c < CARD_TEN) ? c : 4'd0;
  endfunction

endpackage

// File: rtl/baccarat_dealer_hand_score.sv
// Combinational hand score: sum of the three card values modulo 10.
module hand_score
  import baccarat_pkg::*;
(
  input  card_t      c1,
  input  card_t      c2,
  input  card_t      c3,
  output logic [3:0] score
);

  logic [4:0] sum;

  // Sum is at most 27, so two conditional subtractions cover the modulo.
  always_comb begin
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    if (sum >= 5'd20) begin
      score = 4'(sum - 5'd20);
    end else if (sum >= 5'd10) begin
      score = 4'(sum - 5'd10);
    end else begin
      score = sum[3:0];
    end
  end

endmodule

// File: rtl/baccarat_dealer.sv
// One-round baccarat dealer: free-running card source, deal sequencer with
// third-card rules, hand scoring and winner flags.
module baccarat_dealer
  import baccarat_pkg::*;
#(
  parameter int unsigned CARD_MAX = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output card_t      pcard1,
  output card_t      pcard2,
  output card_t      pcard3,
  output card_t      dcard1,
  output card_t      dcard2,
  output card_t      dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done
);

  localparam card_t CardTop = card_t'(CARD_MAX);

  card_t       cnt;
  deal_state_e state, state_next;
  logic        ld_p1, ld_p2, ld_p3, ld_d1, ld_d2, ld_d3;
  logic        bank_draw;
  logic [3:0]  p3_val;

  hand_score u_player_score (
    .c1    (pcard1),
    .c2    (pcard2),
    .c3    (pcard3),
    .score (pscore)
  );

  hand_score u_banker_score (
    .c1    (dcard1),
    .c2    (dcard2),
    .c3    (dcard3),
    .score (dscore)
  );

  // Card source: runs every clock, wraps from the top code back to the ace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CARD_ACE;
    end else if (cnt >= CardTop) begin
      cnt <= CARD_ACE;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  // Banker's reply to a player third card, keyed on the banker two-card score.
  always_comb begin
    p3_val = card_value(pcard3);
    case (dscore)
      4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
      4'd3:             bank_draw = (p3_val != 4'd8);
      4'd4:             bank_draw = (p3_val >= 4'd2) && (p3_val <= 4'd7);
      4'd5:             bank_draw = (p3_val >= 4'd4) && (p3_val <= 4'd7);
      4'd6:             bank_draw = (p3_val >= 4'd6) && (p3_val <= 4'd7);
      default:          bank_draw = 1'b0;
    endcase
  end

  // Deal sequencer: one action per sampled step, S_DONE absorbs until reset.
  always_comb begin
    state_next = state;
    ld_p1 = 1'b0;
    ld_p2 = 1'b0;
    ld_p3 = 1'b0;
    ld_d1 = 1'b0;
    ld_d2 = 1'b0;
    ld_d3 = 1'b0;
    if (step) begin
      case (state)
        S_P1: begin
          ld_p1      = 1'b1;
          state_next = S_D1;
        end
        S_D1: begin
          ld_d1      = 1'b1;
          state_next = S_P2;
        end
        S_P2: begin
          ld_p2      = 1'b1;
          state_next = S_D2;
        end
        S_D2: begin
          ld_d2      = 1'b1;
          state_next = S_THIRD;
        end
        S_THIRD: begin
          if (pscore >= 4'd8 || dscore >= 4'd8) begin
            state_next = S_DONE;
          end else if (pscore <= 4'd5) begin
            ld_p3      = 1'b1;
            state_next = S_BANK;
          end else begin
            ld_d3      = (dscore <= 4'd5);
            state_next = S_DONE;
          end
        end
        S_BANK: begin
          ld_d3      = bank_draw;
          state_next = S_DONE;
        end
        default: state_next = state;
      endcase
    end
  end

  // State and card registers; each card loads only on its own action.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_P1;
      pcard1 <= CARD_BLANK;
      pcard2 <= CARD_BLANK;
      pcard3 <= CARD_BLANK;
      dcard1 <= CARD_BLANK;
      dcard2 <= CARD_BLANK;
      dcard3 <= CARD_BLANK;
    end else begin
      state <= state_next;
      if (ld_p1) pcard1 <= cnt;
      if (ld_p2) pcard2 <= cnt;
      if (ld_p3) pcard3 <= cnt;
      if (ld_d1) dcard1 <= cnt;
      if (ld_d2) dcard2 <= cnt;
      if (ld_d3) dcard3 <= cnt;
    end
  end

  // Result flags are qualified by round completion; a tie leaves both low.
  always_comb begin
    done       = (state == S_DONE);
    player_win = done && (pscore > dscore);
    dealer_win = done && (dscore > pscore);
  end

endmodule
